// File: rtl/me_pkg.sv
// Shared constants, FSM state type and pixel slice helper for the
// motion-estimation row SAD engine.
package me_pkg;

  localparam int PIX_W    = 8;
  localparam int BLK_W    = 16;
  localparam int REF_W    = 23;
  localparam int NCAND    = 8;
  localparam int ROWSAD_W = 12;
  localparam int SAD_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_FLUSH,
    S_CMP,
    S_DONE
  } state_t;

  // Pixel i of a left-justified row (pixel 0 in the top byte). Narrower rows
  // are padded with zeros on the right before calling this.
  function automatic logic [PIX_W-1:0] pix(input logic [REF_W*PIX_W-1:0] row,
                                           input int i);
    return row[REF_W*PIX_W-1-PIX_W*i -: PIX_W];
  endfunction

endpackage

// File: rtl/me_row_sad.sv
// Row SAD for one horizontal candidate: sum of 16 absolute pixel differences
// between a 16-pixel reference window and the current block row.
module me_row_sad
  import me_pkg::*;
(
  input  logic [BLK_W*PIX_W-1:0] ref_win,
  input  logic [BLK_W*PIX_W-1:0] cur_row,
  output logic [ROWSAD_W-1:0]    sad
);

  localparam int PAD_W = (REF_W - BLK_W) * PIX_W;

  logic [REF_W*PIX_W-1:0] ref_pad;
  logic [REF_W*PIX_W-1:0] cur_pad;
  logic [BLK_W-1:0][PIX_W-1:0] diff;

  assign ref_pad = {ref_win, {PAD_W{1'b0}}};
  assign cur_pad = {cur_row, {PAD_W{1'b0}}};

  for (genvar j = 0; j < BLK_W; j++) begin : g_diff
    logic [PIX_W-1:0] a, b;
    assign a       = pix(ref_pad, j);
    assign b       = pix(cur_pad, j);
    assign diff[j] = (a > b) ? (a - b) : (b - a);
  end

  // Sum the 16 abs diffs; the maximum 16*255 = 4080 fits in 12 bits.
  always_comb begin
    sad = '0;
    for (int j = 0; j < BLK_W; j++) sad = sad + ROWSAD_W'(diff[j]);
  end

endmodule

// File: rtl/me_row_sad_engine.sv
// Accumulates 8 horizontal-candidate SADs over a 16-row block, then scans
// them for the minimum and presents the winner on a valid/ready output.
module me_row_sad_engine
  import me_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int NCAND = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REF_W*PIX_W-1:0] ref_row,
  input  logic [BLK_W*PIX_W-1:0] cur_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             best_mv,
  output logic [SAD_W-1:0]       best_sad
);

  localparam int CNT_W = $clog2(ROWS);

  state_t                          state;
  logic [CNT_W-1:0]                row_cnt;
  logic [2:0]                      cmp_k;
  logic                            accept;
  logic                            s1_vld;
  logic [NCAND-1:0][ROWSAD_W-1:0]  row_sad;
  logic [NCAND-1:0][ROWSAD_W-1:0]  s1_sad;
  logic [NCAND-1:0][SAD_W-1:0]     acc;

  // in_ready is a register, so accept has no path from out_ready.
  assign accept = in_valid && in_ready && !flush;

  for (genvar k = 0; k < NCAND; k++) begin : g_cand
    me_row_sad u_row_sad (
      .ref_win (ref_row[REF_W*PIX_W-1-PIX_W*k -: BLK_W*PIX_W]),
      .cur_row (cur_row),
      .sad     (row_sad[k])
    );
  end

  // Stage 1: capture the row SADs of each accepted row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_sad <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_sad <= row_sad;
    end
  end

  // Stage 2: accumulate; cleared by the first row of a new block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (accept && state == S_IDLE) begin
      acc <= '0;
    end else if (s1_vld) begin
      for (int k = 0; k < NCAND; k++) acc[k] <= acc[k] + SAD_W'(s1_sad[k]);
    end
  end

  // Control FSM with registered handshake flags and the min-SAD scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      cmp_k     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      best_mv   <= '0;
      best_sad  <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      cmp_k     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            row_cnt <= CNT_W'(1);
            state   <= S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            // Wraps back to zero on the last row of the block.
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == CNT_W'(ROWS - 1)) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // Last row's stage-1 sums drain into acc this cycle.
          cmp_k <= '0;
          state <= S_CMP;
        end
        S_CMP: begin
          // Strict less-than keeps the lowest offset on ties.
          if (cmp_k == '0 || acc[cmp_k] < best_sad) begin
            best_sad <= acc[cmp_k];
            best_mv  <= cmp_k;
          end
          if (cmp_k == 3'(NCAND - 1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cmp_k <= cmp_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
